cordic_arb: RTL

CORDIC_ARB -- requirements
Module: cordic_arb

---
 rtl/cordic_arb.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cordic_arb.sv
// Two-requester round-robin front end for a LAT-deep enabled CORDIC pipeline, with result routing and flush drain.
// Optional per-requester saturating issue counters are enabled by defining CORDIC_ARB_STATS_EN.
module cordic_arb #(
  parameter int unsigned IW  = 10,
  parameter int unsigned OW  = 10,
  parameter int unsigned PW  = 14,
  parameter int unsigned LAT = 12
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [1:0]           i_req_valid,
  output logic [1:0]           o_req_ready,
  input  logic signed [IW-1:0] i_req_x0,
  input  logic signed [IW-1:0] i_req_y0,
  input  logic signed [IW-1:0] i_req_x1,
  input  logic signed [IW-1:0] i_req_y1,
  input  logic [PW-1:0]        i_req_ph0,
  input  logic [PW-1:0]        i_req_ph1,
  output logic signed [IW-1:0] o_cx,
  output logic signed [IW-1:0] o_cy,
  output logic [PW-1:0]        o_cph,
  output logic                 o_caux,
  output logic                 o_cen,
  input  logic signed [OW-1:0] i_rx,
  input  logic signed [OW-1:0] i_ry,
  input  logic                 i_raux,
  output logic [1:0]           o_res_valid,
  input  logic [1:0]           i_res_ready,
  output logic signed [OW-1:0] o_res_x,
  output logic signed [OW-1:0] o_res_y,
  input  logic                 i_flush,
  output logic                 o_flush_done,
  output logic                 o_busy
`ifdef CORDIC_ARB_STATS_EN
  ,
  output logic [15:0]          o_stat_iss0,
  output logic [15:0]          o_stat_iss1
`endif
);

  localparam int unsigned CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LAT-1:0]  tag_q;
  logic            tag_out;
  logic            gnt_id;
  logic            issue;
  logic            consume;

  // Result routing: the tag leaving the pipeline names the owner of i_raux.
  assign tag_out     = tag_q[LAT-1];
  assign o_cen       = !(i_raux && !i_res_ready[tag_out]);
  assign o_res_valid = {i_raux & tag_out, i_raux & ~tag_out};
  assign o_res_x     = i_rx;
  assign o_res_y     = i_ry;
  assign consume     = |(o_res_valid & i_res_ready);
  assign o_busy      = (cnt_q != '0);
  assign o_flush_done = (state_q == ST_DONE);

  // Round-robin grant; last_q remembers the previous winner.
  always_comb begin
    gnt_id = i_req_valid[1];
    if (&i_req_valid) gnt_id = ~last_q;
  end

  assign issue       = (state_q == ST_RUN) && o_cen && (|i_req_valid) && !i_reset;
  assign o_req_ready = issue ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    o_cx   = '0;
    o_cy   = '0;
    o_cph  = '0;
    o_caux = 1'b0;
    last_d = last_q;
    if (issue) begin
      o_caux = 1'b1;
      last_d = gnt_id;
      if (gnt_id) begin
        o_cx  = i_req_x1;
        o_cy  = i_req_y1;
        o_cph = i_req_ph1;
      end else begin
        o_cx  = i_req_x0;
        o_cy  = i_req_y0;
        o_cph = i_req_ph0;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (issue && !consume)      cnt_d = cnt_q + CW'(1);
    else if (!issue && consume) cnt_d = cnt_q - CW'(1);
  end

  // Flush: stop issuing, wait for the last in-flight result, pulse done once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (i_flush) state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_d == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      if (o_cen) tag_q <= {tag_q[LAT-2:0], gnt_id & issue};
    end
  end

`ifdef CORDIC_ARB_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stat_iss0 <= '0;
      o_stat_iss1 <= '0;
    end else begin
      if (o_req_ready[0] && (o_stat_iss0 != 16'hFFFF)) o_stat_iss0 <= o_stat_iss0 + 16'd1;
      if (o_req_ready[1] && (o_stat_iss1 != 16'hFFFF)) o_stat_iss1 <= o_stat_iss1 + 16'd1;
    end
  end
`endif

endmodule
